// File: rtl/fp_gt_arbiter_if.sv
// rtl/fp_gt_arbiter_if.sv - request/response bus between compare clients and fp_gt_arbiter
interface fp_gt_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_gt;

  // Client side: presents operand pairs, consumes tagged results
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt
  );
endinterface

// File: rtl/fp_gt_arbiter.sv
// rtl/fp_gt_arbiter.sv - round-robin sharing of one fp_gt comparator; FP_GT_ARB_STATS_EN adds response counters

// Single-precision a > b. NaN on either side gives 0, +0 and -0 compare equal.
module fp_gt (
  input  logic [31:0] f1,
  input  logic [31:0] f2,
  output logic        out
);
  logic        nan1;
  logic        nan2;
  logic [30:0] mag1;
  logic [30:0] mag2;

  // Sign/magnitude ordering with the IEEE special cases peeled off first
  always_comb begin
    mag1 = f1[30:0];
    mag2 = f2[30:0];
    nan1 = (f1[30:23] == 8'hFF) && (f1[22:0] != 23'd0);
    nan2 = (f2[30:23] == 8'hFF) && (f2[22:0] != 23'd0);
    if (nan1 || nan2) begin
      out = 1'b0;
    end else if ((mag1 == 31'd0) && (mag2 == 31'd0)) begin
      out = 1'b0;
    end else if (f1[31] != f2[31]) begin
      out = f2[31];
    end else if (!f1[31]) begin
      out = (mag1 > mag2);
    end else begin
      out = (mag1 < mag2);
    end
  end
endmodule

module fp_gt_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_gt_arbiter_if.slave        bus,
  output logic [15:0]           cmp_count,
  output logic [15:0]           gt_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_d;
  logic [31:0]     op_a_q;
  logic [31:0]     op_a_d;
  logic [31:0]     op_b_q;
  logic [31:0]     op_b_d;
  logic            rsp_valid_q;
  logic            rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q;
  logic [IDW-1:0]  rsp_id_d;
  logic            rsp_gt_q;
  logic            rsp_gt_d;

  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic [IDW-1:0]  cand;
  int              idx;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [NREQ-1:0] ready;
  logic            gt_w;

  fp_gt u_fp_gt (
    .f1  (op_a_q),
    .f2  (op_b_q),
    .out (gt_w)
  );

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(rr_ptr_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a = 32'd0;
    sel_b = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  // Accept is combinational and only offered while idle; held off during reset
  always_comb begin
    ready = '0;
    if (rst_n && (state_q == IDLE) && grant_vld) begin
      ready[grant] = 1'b1;
    end
  end

  // Sequencer next state: accept -> compare -> hold response until consumed
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_gt_d    = rsp_gt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          id_d     = grant;
          rr_ptr_d = IDW'((int'(grant) + 1) % NREQ);
          state_d  = CMP;
        end
      end
      CMP: begin
        rsp_gt_d    = gt_w;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // The handshake cycle never accepts; the next grant is one cycle later
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gt_q    <= rsp_gt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_gt    = rsp_gt_q;

`ifdef FP_GT_ARB_STATS_EN
  logic        rsp_hs;
  logic [15:0] cmp_count_q;
  logic [15:0] cmp_count_d;
  logic [15:0] gt_count_q;
  logic [15:0] gt_count_d;

  assign rsp_hs = rsp_valid_q && bus.rsp_ready;

  // Saturating tallies of consumed responses and of true results among them
  always_comb begin
    cmp_count_d = cmp_count_q;
    gt_count_d  = gt_count_q;
    if (rsp_hs) begin
      if (cmp_count_q != 16'hFFFF) begin
        cmp_count_d = cmp_count_q + 16'd1;
      end
      if (rsp_gt_q && (gt_count_q != 16'hFFFF)) begin
        gt_count_d = gt_count_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_count_q <= 16'd0;
      gt_count_q  <= 16'd0;
    end else begin
      cmp_count_q <= cmp_count_d;
      gt_count_q  <= gt_count_d;
    end
  end

  assign cmp_count = cmp_count_q;
  assign gt_count  = gt_count_q;
`else
  assign cmp_count = 16'h0000;
  assign gt_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_gt_arbiter.sv
// tb/tb_fp_gt_arbiter.sv - randomized self-checking bench for fp_gt_arbiter
module tb_fp_gt_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmp_count;
  logic [15:0] gt_count;

  fp_gt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp_gt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cmp_count (cmp_count),
    .gt_count  (gt_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  int m_ptr = 0;
  int m_cmp = 0;
  int m_gt  = 0;

  // Numeric value of a float32; infinities become huge finite reals
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'hFF) begin
      m = 1.0e300;
    end else begin
      if (f[30:23] == 8'd0) begin
        m = real'(f[22:0]);
        e = -149;
      end else begin
        m = real'({1'b1, f[22:0]});
        e = int'(f[30:23]) - 150;
      end
      m = m * (2.0 ** e);
    end
    return f[31] ? -m : m;
  endfunction

  function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
    return f2r(a) > f2r(b);
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      1: r = 32'h0000_0000;
      2: r = 32'h8000_0000;
      3: r = 32'h7F80_0000;
      4: r = 32'hFF80_0000;
      5: r = 32'h7FC0_0001;
      6: r = {r[31], 8'h00, r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'd0;
      op_b[i] = 32'd0;
    end
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    m_cmp = 0;
    m_gt  = 0;
  endtask

  task automatic note_hs(input bit g);
    m_cmp = m_cmp + 1;
    if (g) m_gt = m_gt + 1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL reset_rsp_gt got=%0b exp=0", bus.rsp_gt); end
    checks++; if (cmp_count !== 16'd0 || gt_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", cmp_count, gt_count); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL idle_after_reset got=%0b/%b exp=0/0000", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_single();
    op_a[2] = 32'h4000_0000;
    op_b[2] = 32'h3F80_0000;
    drive();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    checks++; if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_cmp got=%b/%0b exp=0000/0", bus.req_ready, bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_gt !== 1'b1) begin errors++; $display("FAIL single_rsp got=v%0b id%0d gt%0b exp=v1 id2 gt1", bus.rsp_valid, bus.rsp_id, bus.rsp_gt); end
    tick();
    note_hs(1'b1);
    m_ptr = 3;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%0b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int prev;
    int e;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'h3F80_0000;
      op_b[i] = 32'h4000_0000;
    end
    drive();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      e = n % NREQ;
      #1;
      checks++; if (bus.req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_grant%0d got=%b exp_id=%0d", n, bus.req_ready, e); end
      if (n > 0) begin
        checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL rr_spacing%0d got=%0d exp=3", n, cyc - prev); end
      end
      prev = cyc;
      tick();
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e[IDW-1:0] || bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL rr_rsp%0d got=v%0b id%0d gt%0b exp=v1 id%0d gt0", n, bus.rsp_valid, bus.rsp_id, bus.rsp_gt, e); end
      tick();
      note_hs(1'b0);
      m_ptr = (e + 1) % NREQ;
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    op_a[0] = 32'hBF80_0000; op_b[0] = 32'hC000_0000;
    op_a[1] = 32'h0000_0000; op_b[1] = 32'h8000_0000;
    drive();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL bp_rsp got=v%0b id%0d gt%0b exp=v1 id1 gt0", bus.rsp_valid, bus.rsp_id, bus.rsp_gt); end
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_gt !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_hold%0d got=v%0b id%0d gt%0b rdy%b exp=v1 id1 gt0 rdy0000", n, bus.rsp_valid, bus.rsp_id, bus.rsp_gt, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_hs_cycle got=%b exp=0000", bus.req_ready); end
    tick();
    note_hs(1'b0);
    m_ptr = 2;
    checks++; if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next_grant got=%b/%0b exp=0001/0", bus.req_ready, bus.rsp_valid); end
    tick();
    bus.req_valid = 4'b0000;
    m_ptr = 1;
    tick();
    checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_gt !== 1'b1) begin errors++; $display("FAIL bp_second_rsp got=id%0d gt%0b exp=id0 gt1", bus.rsp_id, bus.rsp_gt); end
    tick();
    note_hs(1'b1);
  endtask

  task automatic test_equal();
    op_a[3] = 32'h42C8_0000;
    op_b[3] = 32'h42C8_0000;
    drive();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL eq_grant got=%b exp=1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    m_ptr = 0;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL eq_rsp got=v%0b gt%0b exp=v1 gt0", bus.rsp_valid, bus.rsp_gt); end
    tick();
    note_hs(1'b0);
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL rm_cmp_reset got=%0b/%b exp=0/0000", bus.rsp_valid, bus.req_ready); end
    tick();
    rst_n = 1'b1;
    m_ptr = 0; m_cmp = 0; m_gt = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d got=%0b exp=0", n, bus.rsp_valid); end
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_zero got=%b exp=0001", bus.req_ready); end
    op_a[3] = 32'h4000_0000;
    op_b[3] = 32'h3F80_0000;
    drive();
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rm_withdraw got=%b exp=1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_gt !== 1'b1) begin errors++; $display("FAIL rm_resp got=v%0b id%0d gt%0b exp=v1 id3 gt1", bus.rsp_valid, bus.rsp_id, bus.rsp_gt); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_gt !== 1'b0) begin errors++; $display("FAIL rm_async got=v%0b id%0d gt%0b exp=v0 id0 gt0", bus.rsp_valid, bus.rsp_id, bus.rsp_gt); end
    tick();
    rst_n = 1'b1;
    m_ptr = 0; m_cmp = 0; m_gt = 0;
    tick();
  endtask

  task automatic test_stats();
    int ec;
    int eg;
    op_a[0] = 32'h4000_0000; op_b[0] = 32'h3F80_0000;
    op_a[1] = 32'h3F80_0000; op_b[1] = 32'h4000_0000;
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h3F80_0000;
    drive();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0111;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (bus.req_ready !== (4'b0001 << n)) begin errors++; $display("FAIL st_grant%0d got=%b exp_id=%0d", n, bus.req_ready, n); end
      tick();
      bus.req_valid[n] = 1'b0;
      tick();
      checks++; if (bus.rsp_gt !== ((n == 1) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL st_gt%0d got=%0b", n, bus.rsp_gt); end
      tick();
      note_hs(n != 1);
      m_ptr = n + 1;
    end
`ifdef FP_GT_ARB_STATS_EN
    ec = 3; eg = 2;
`else
    ec = 0; eg = 0;
`endif
    checks++; if (cmp_count !== 16'(ec) || gt_count !== 16'(eg)) begin errors++; $display("FAIL st_counts got=%0d/%0d exp=%0d/%0d", cmp_count, gt_count, ec, eg); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    int e;
    int bp;
    bit g;
    int ec;
    int eg;
    for (int t = 0; t < 200; t++) begin
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = rand_f();
        op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : rand_f();
      end
      drive();
      mask = NREQ'($urandom);
      bus.req_valid = mask;
      #1;
      e = exp_grant(mask);
      if (e < 0) begin
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rnd_idle%0d got=%b exp=0000", t, bus.req_ready); end
        tick();
        continue;
      end
      checks++; if (bus.req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rnd_grant%0d got=%b exp_id=%0d mask=%b", t, bus.req_ready, e, mask); end
      g = ref_gt(op_a[e], op_b[e]);
      tick();
      m_ptr = (e + 1) % NREQ;
      bus.req_valid = NREQ'($urandom);
      op_a[e] = rand_f();
      drive();
      #1;
      checks++; if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_cmp%0d got=%b/%0b exp=0000/0", t, bus.req_ready, bus.rsp_valid); end
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e[IDW-1:0] || bus.rsp_gt !== g) begin errors++; $display("FAIL rnd_rsp%0d got=v%0b id%0d gt%0b exp=v1 id%0d gt%0b", t, bus.rsp_valid, bus.rsp_id, bus.rsp_gt, e, g); end
      bp = $urandom_range(0, 3);
      for (int n = 0; n < bp; n++) begin
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e[IDW-1:0] || bus.rsp_gt !== g || bus.req_ready !== 4'b0) begin errors++; $display("FAIL rnd_hold%0d got=v%0b id%0d gt%0b rdy%b", t, bus.rsp_valid, bus.rsp_id, bus.rsp_gt, bus.req_ready); end
      end
      bus.rsp_ready = 1'b1;
      tick();
      note_hs(g);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop%0d got=%0b exp=0", t, bus.rsp_valid); end
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
`ifdef FP_GT_ARB_STATS_EN
    ec = (m_cmp > 65535) ? 65535 : m_cmp;
    eg = (m_gt > 65535) ? 65535 : m_gt;
`else
    ec = 0; eg = 0;
`endif
    checks++; if (cmp_count !== 16'(ec) || gt_count !== 16'(eg)) begin errors++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", cmp_count, gt_count, ec, eg); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_equal();
    test_reset_mid();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
